// File: rtl/dmem_arbiter_if.sv
// Bundle of every signal between the dmem_arbiter, its two requesters and the
// data memory. The slave modport is the arbiter's view; master is the
// environment's view (core, debug port and memory together).
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BURST  = 4
) ();
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(MAX_BURST + 1);

    // CPU port
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [STRB_W-1:0]     cpu_wstrb;
    logic                  cpu_gnt;
    logic                  cpu_stall;
    logic                  cpu_rvalid;
    logic [DATA_WIDTH-1:0] cpu_rdata;

    // Debug/loader port
    logic                  dbg_req;
    logic                  dbg_we;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_wdata;
    logic [STRB_W-1:0]     dbg_wstrb;
    logic                  dbg_lock;
    logic                  dbg_gnt;
    logic                  dbg_rvalid;
    logic [DATA_WIDTH-1:0] dbg_rdata;

    // Memory side
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [STRB_W-1:0]     mem_wstrb;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Arbiter state exposed for observation (1 = debug granted last)
    logic                  st_last_gnt;
    logic [CNT_W-1:0]      st_burst_cnt;
    logic                  st_rd_pend;
    logic                  st_rd_owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_wstrb, dbg_lock,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata,
        output st_last_gnt, st_burst_cnt, st_rd_pend, st_rd_owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_wstrb, dbg_lock,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata,
        input  st_last_gnt, st_burst_cnt, st_rd_pend, st_rd_owner
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: CPU load/store path
// versus debug/loader port. Grants at most one access per cycle, steers read
// data back to the port that issued the read one cycle later, and limits how
// long a locked debug burst can hold off the CPU.
//
// Handshake: a requester raises req with its fields stable and holds them
// until it sees gnt in the same cycle; gnt is combinational, so a granted
// request completes on that clock edge. Dropping req before gnt withdraws the
// request with no side effects. Read data returns as an rvalid pulse with
// rdata exactly one cycle after the read grant and cannot be back-pressured.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic            clk,
    input  logic            rst,
    dmem_arbiter_if.slave   bus
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    logic             last_gnt;
    logic [CNT_W-1:0] burst_cnt;
    logic             rd_pend;
    logic             rd_owner;
    logic             cpu_gnt;
    logic             dbg_gnt;

    // Pick the winner for this cycle from live requests and registered state.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (!rst) begin
            if (bus.cpu_req && !bus.dbg_req) begin
                cpu_gnt = 1'b1;
            end else if (bus.dbg_req && !bus.cpu_req) begin
                dbg_gnt = 1'b1;
            end else if (bus.cpu_req && bus.dbg_req) begin
                if (bus.dbg_lock) begin
                    // Locked burst: debug wins until it has used its quota.
                    if (burst_cnt < MAX_CNT) dbg_gnt = 1'b1;
                    else                     cpu_gnt = 1'b1;
                end else begin
                    // Round-robin: whoever was not granted last goes now.
                    if (last_gnt == PORT_DBG) cpu_gnt = 1'b1;
                    else                      dbg_gnt = 1'b1;
                end
            end
        end
    end

    // Steer the granted port onto the memory bus; zeros when idle.
    always_comb begin
        bus.mem_en    = cpu_gnt | dbg_gnt;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        if (cpu_gnt) begin
            bus.mem_we    = bus.cpu_we;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
            bus.mem_wstrb = bus.cpu_wstrb;
        end else if (dbg_gnt) begin
            bus.mem_we    = bus.dbg_we;
            bus.mem_addr  = bus.dbg_addr;
            bus.mem_wdata = bus.dbg_wdata;
            bus.mem_wstrb = bus.dbg_wstrb;
        end
    end

    // Remember the last winner for round-robin tie breaking.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= PORT_DBG;
        end else if (cpu_gnt) begin
            last_gnt <= PORT_CPU;
        end else if (dbg_gnt) begin
            last_gnt <= PORT_DBG;
        end
    end

    // Count debug grants that the CPU has been waiting through.
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt <= '0;
        end else if (cpu_gnt || !bus.cpu_req) begin
            burst_cnt <= '0;
        end else if (dbg_gnt && burst_cnt < MAX_CNT) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

    // Track which port owns the read data arriving next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend  <= 1'b0;
            rd_owner <= PORT_CPU;
        end else begin
            rd_pend  <= bus.mem_en & ~bus.mem_we;
            rd_owner <= dbg_gnt;
        end
    end

    // Return read data to its owner only; the other port sees zeros. Gated by
    // rst so a read in flight when reset arrives is dropped.
    always_comb begin
        bus.cpu_rvalid = rd_pend & ~rst & (rd_owner == PORT_CPU);
        bus.dbg_rvalid = rd_pend & ~rst & (rd_owner == PORT_DBG);
        bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;
        bus.dbg_rdata  = bus.dbg_rvalid ? bus.mem_rdata : '0;
    end

    assign bus.cpu_gnt      = cpu_gnt;
    assign bus.dbg_gnt      = dbg_gnt;
    assign bus.cpu_stall    = bus.cpu_req & ~cpu_gnt;
    assign bus.st_last_gnt  = last_gnt;
    assign bus.st_burst_cnt = burst_cnt;
    assign bus.st_rd_pend   = rd_pend;
    assign bus.st_rd_owner  = rd_owner;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: hand-computed expectations checked with
// immediate assertions, one linear stimulus sequence.
module tb_dmem_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MB = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) bus ();

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and let combinational outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_all();
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.cpu_wstrb = '0;
        bus.dbg_req   = 1'b0;
        bus.dbg_we    = 1'b0;
        bus.dbg_addr  = '0;
        bus.dbg_wdata = '0;
        bus.dbg_wstrb = '0;
        bus.dbg_lock  = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic drive_cpu(input logic req, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [DW/8-1:0] wstrb);
        bus.cpu_req   = req;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        bus.cpu_wstrb = wstrb;
    endtask

    task automatic drive_dbg(input logic req, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [DW/8-1:0] wstrb,
                             input logic lock);
        bus.dbg_req   = req;
        bus.dbg_we    = we;
        bus.dbg_addr  = addr;
        bus.dbg_wdata = wdata;
        bus.dbg_wstrb = wstrb;
        bus.dbg_lock  = lock;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b1;
        idle_all();
        tick();

        // Grants gated during reset even with a request pending.
        drive_cpu(1'b1, 1'b0, 32'h10, '0, '0);
        settle();
        chk("rst_cpu_gnt", 64'(bus.cpu_gnt), 64'd0);
        chk("rst_mem_en", 64'(bus.mem_en), 64'd0);
        tick();
        idle_all();
        rst = 1'b0;
        settle();

        // Reset state
        chk("rst_last_gnt", 64'(bus.st_last_gnt), 64'd1);
        chk("rst_burst_cnt", 64'(bus.st_burst_cnt), 64'd0);
        chk("rst_rd_pend", 64'(bus.st_rd_pend), 64'd0);
        chk("rst_cpu_rvalid", 64'(bus.cpu_rvalid), 64'd0);
        chk("rst_dbg_rvalid", 64'(bus.dbg_rvalid), 64'd0);
        chk("rst_cpu_rdata", 64'(bus.cpu_rdata), 64'd0);
        chk("idle_mem_addr", 64'(bus.mem_addr), 64'd0);

        // Lone CPU read of 0x10
        drive_cpu(1'b1, 1'b0, 32'h10, '0, '0);
        settle();
        chk("rd_cpu_gnt", 64'(bus.cpu_gnt), 64'd1);
        chk("rd_cpu_stall", 64'(bus.cpu_stall), 64'd0);
        chk("rd_mem_en", 64'(bus.mem_en), 64'd1);
        chk("rd_mem_we", 64'(bus.mem_we), 64'd0);
        chk("rd_mem_addr", 64'(bus.mem_addr), 64'h10);
        tick();
        idle_all();
        bus.mem_rdata = 32'hDEADBEEF;
        settle();
        chk("rd_cpu_rvalid", 64'(bus.cpu_rvalid), 64'd1);
        chk("rd_cpu_rdata", 64'(bus.cpu_rdata), 64'hDEADBEEF);
        chk("rd_dbg_rvalid", 64'(bus.dbg_rvalid), 64'd0);
        chk("rd_dbg_rdata", 64'(bus.dbg_rdata), 64'd0);
        tick();
        chk("rd_cpu_rvalid_gone", 64'(bus.cpu_rvalid), 64'd0);

        // Round-robin: both write continuously, CPU first after reset
        do_reset();
        drive_cpu(1'b1, 1'b1, 32'h100, 32'h1111_1111, 4'hF);
        drive_dbg(1'b1, 1'b1, 32'h200, 32'h2222_2222, 4'hF, 1'b0);
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("rr_cpu_gnt", 64'(bus.cpu_gnt), 64'((i % 2) == 0));
            chk("rr_dbg_gnt", 64'(bus.dbg_gnt), 64'((i % 2) == 1));
            chk("rr_cpu_stall", 64'(bus.cpu_stall), 64'((i % 2) == 1));
            chk("rr_mem_addr", 64'(bus.mem_addr), ((i % 2) == 0) ? 64'h100 : 64'h200);
            tick();
        end

        // Locked burst: DBG x4, CPU x1, repeating
        idle_all();
        tick();
        drive_cpu(1'b1, 1'b1, 32'h100, 32'h1111_1111, 4'hF);
        drive_dbg(1'b1, 1'b1, 32'h200, 32'h2222_2222, 4'hF, 1'b1);
        for (int i = 0; i < 7; i++) begin
            settle();
            chk("lk_burst_cnt", 64'(bus.st_burst_cnt), 64'(i % 5));
            chk("lk_dbg_gnt", 64'(bus.dbg_gnt), 64'((i % 5) != 4));
            chk("lk_cpu_gnt", 64'(bus.cpu_gnt), 64'((i % 5) == 4));
            tick();
        end
        // CPU drops its request: count clears
        bus.cpu_req = 1'b0;
        settle();
        chk("lk_burst_before_drop", 64'(bus.st_burst_cnt), 64'd2);
        chk("lk_dbg_alone_gnt", 64'(bus.dbg_gnt), 64'd1);
        tick();
        chk("lk_burst_cleared", 64'(bus.st_burst_cnt), 64'd0);

        // Alternating reads CPU 0x4 -> 0x11, DBG 0x8 -> 0x22
        idle_all();
        tick();
        drive_cpu(1'b1, 1'b0, 32'h4, '0, '0);
        settle();
        chk("alt_cpu_gnt", 64'(bus.cpu_gnt), 64'd1);
        tick();
        drive_cpu(1'b0, 1'b0, '0, '0, '0);
        drive_dbg(1'b1, 1'b0, 32'h8, '0, '0, 1'b0);
        bus.mem_rdata = 32'h11;
        settle();
        chk("alt_dbg_gnt", 64'(bus.dbg_gnt), 64'd1);
        chk("alt_mem_addr", 64'(bus.mem_addr), 64'h8);
        chk("alt_cpu_rvalid", 64'(bus.cpu_rvalid), 64'd1);
        chk("alt_cpu_rdata", 64'(bus.cpu_rdata), 64'h11);
        chk("alt_dbg_rvalid0", 64'(bus.dbg_rvalid), 64'd0);
        tick();
        idle_all();
        bus.mem_rdata = 32'h22;
        settle();
        chk("alt_dbg_rvalid", 64'(bus.dbg_rvalid), 64'd1);
        chk("alt_dbg_rdata", 64'(bus.dbg_rdata), 64'h22);
        chk("alt_cpu_rvalid0", 64'(bus.cpu_rvalid), 64'd0);
        chk("alt_cpu_rdata0", 64'(bus.cpu_rdata), 64'd0);
        tick();

        // Debug write 0x20, no read return
        idle_all();
        drive_dbg(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 4'h3, 1'b0);
        settle();
        chk("wr_mem_en", 64'(bus.mem_en), 64'd1);
        chk("wr_mem_we", 64'(bus.mem_we), 64'd1);
        chk("wr_mem_wstrb", 64'(bus.mem_wstrb), 64'h3);
        chk("wr_mem_wdata", 64'(bus.mem_wdata), 64'hA5A5A5A5);
        chk("wr_mem_addr", 64'(bus.mem_addr), 64'h20);
        tick();
        idle_all();
        bus.mem_rdata = 32'h5555_AAAA;
        settle();
        chk("wr_cpu_rvalid", 64'(bus.cpu_rvalid), 64'd0);
        chk("wr_dbg_rvalid", 64'(bus.dbg_rvalid), 64'd0);
        tick();

        // CPU read, then reset in the next cycle drops the return
        drive_cpu(1'b1, 1'b0, 32'h30, '0, '0);
        settle();
        chk("rr2_cpu_gnt", 64'(bus.cpu_gnt), 64'd1);
        tick();
        idle_all();
        rst = 1'b1;
        bus.mem_rdata = 32'hCAFE_F00D;
        settle();
        chk("rst_mid_cpu_rvalid", 64'(bus.cpu_rvalid), 64'd0);
        chk("rst_mid_cpu_rdata", 64'(bus.cpu_rdata), 64'd0);
        tick();
        rst = 1'b0;
        settle();
        chk("rst_after_cpu_rvalid", 64'(bus.cpu_rvalid), 64'd0);
        // First tie after reset goes to CPU
        drive_cpu(1'b1, 1'b1, 32'h40, 32'h1, 4'h1);
        drive_dbg(1'b1, 1'b1, 32'h50, 32'h2, 4'h1, 1'b0);
        settle();
        chk("tie_cpu_gnt", 64'(bus.cpu_gnt), 64'd1);
        chk("tie_dbg_gnt", 64'(bus.dbg_gnt), 64'd0);
        tick();
        idle_all();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
